// File: rtl/nested_index_counter.sv
// Multi-level odometer index sequencer with valid/ready output, per-level last flags
// and an optional lower-triangular innermost level.
module nested_index_counter #(
    parameter int NUM_LEVELS = 2,
    parameter int WIDTH      = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          clear,
    input  logic [NUM_LEVELS*WIDTH-1:0]   limit,
    input  logic                          tri_mode,
    output logic [NUM_LEVELS*WIDTH-1:0]   idx,
    output logic                          valid,
    input  logic                          ready,
    output logic [NUM_LEVELS-1:0]         last,
    output logic                          busy,
    output logic                          done
);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    localparam int             L1  = (NUM_LEVELS > 1) ? 1 : 0;
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state;
    logic [WIDTH-1:0] idx_q   [NUM_LEVELS];
    logic [WIDTH-1:0] lim_q   [NUM_LEVELS];
    logic [WIDTH-1:0] idx_nxt [NUM_LEVELS];
    logic             tri_q;
    logic             tri_en;
    logic [NUM_LEVELS-1:0] last_c;

    // A zero bound on any counted level means the sequence has no tuples at all.
    function automatic logic is_empty(input logic [NUM_LEVELS*WIDTH-1:0] lim, input logic tri_m);
        logic e;
        e = 1'b0;
        for (int l = 0; l < NUM_LEVELS; l++) begin
            if (lim[l*WIDTH +: WIDTH] == '0 && (l != 0 || !tri_m))
                e = 1'b1;
        end
        return e;
    endfunction

    assign tri_en = tri_mode & (NUM_LEVELS > 1);

    // Carry chain: a level advances only when every inner level sits at its final value.
    always_comb begin
        logic             carry;
        logic             fin;
        logic [WIDTH-1:0] bound;
        carry = 1'b1;
        for (int l = 0; l < NUM_LEVELS; l++) begin
            if (l == 0 && tri_q)
                bound = idx_q[L1];
            else
                bound = lim_q[l] - ONE;
            fin        = (idx_q[l] == bound);
            idx_nxt[l] = carry ? (fin ? '0 : idx_q[l] + ONE) : idx_q[l];
            carry      = carry & fin;
            last_c[l]  = valid & carry;
        end
    end

    assign last = last_c;

    for (genvar g = 0; g < NUM_LEVELS; g++) begin : g_idx
        assign idx[g*WIDTH +: WIDTH] = idx_q[g];
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state <= IDLE;
            valid <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            tri_q <= 1'b0;
            for (int l = 0; l < NUM_LEVELS; l++) begin
                idx_q[l] <= '0;
                lim_q[l] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        tri_q <= tri_en;
                        for (int l = 0; l < NUM_LEVELS; l++) begin
                            lim_q[l] <= limit[l*WIDTH +: WIDTH];
                            idx_q[l] <= '0;
                        end
                        if (is_empty(limit, tri_en)) begin
                            state <= FIN;
                            done  <= 1'b1;
                        end else begin
                            state <= RUN;
                            valid <= 1'b1;
                            busy  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (valid && ready) begin
                        if (last_c[NUM_LEVELS-1]) begin
                            state <= FIN;
                            valid <= 1'b0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            for (int l = 0; l < NUM_LEVELS; l++)
                                idx_q[l] <= '0;
                        end else begin
                            for (int l = 0; l < NUM_LEVELS; l++)
                                idx_q[l] <= idx_nxt[l];
                        end
                    end
                end
                FIN: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nested_index_counter.sv
// Bench for nested_index_counter: a 2-level instance for the tuple-order scenarios and
// a 1-level instance for the full-range count.
module tb_nested_index_counter;

    typedef struct {
        logic [7:0] i1;
        logic [7:0] i0;
        logic [1:0] lst;
    } tup_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        clear = 1'b0;
    logic [15:0] limit = '0;
    logic        tri_mode = 1'b0;
    logic [15:0] idx;
    logic        valid;
    logic        ready = 1'b0;
    logic [1:0]  last;
    logic        busy;
    logic        done;

    logic        s_start = 1'b0;
    logic        s_clear = 1'b0;
    logic [7:0]  s_limit = '0;
    logic        s_tri = 1'b0;
    logic [7:0]  s_idx;
    logic        s_valid;
    logic        s_ready = 1'b1;
    logic [0:0]  s_last;
    logic        s_busy;
    logic        s_done;

    int checks = 0;
    int failures = 0;
    tup_t sb[$];
    int   sq[$];

    always #5 clk = ~clk;

    nested_index_counter #(.NUM_LEVELS(2), .WIDTH(8)) u_dut (
        .clk(clk), .rst(rst), .start(start), .clear(clear), .limit(limit),
        .tri_mode(tri_mode), .idx(idx), .valid(valid), .ready(ready),
        .last(last), .busy(busy), .done(done)
    );

    nested_index_counter #(.NUM_LEVELS(1), .WIDTH(8)) u_one (
        .clk(clk), .rst(rst), .start(s_start), .clear(s_clear), .limit(s_limit),
        .tri_mode(s_tri), .idx(s_idx), .valid(s_valid), .ready(s_ready),
        .last(s_last), .busy(s_busy), .done(s_done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts a 2-level sequence and scores every presented tuple against the model queue.
    // Returns in the cycle where done is observed (the DUT is then in FIN).
    task automatic run_seq(input int l1, input int l0, input bit trm, input int mode, input string nm);
        tup_t e;
        int   n;
        bit   seen_done;
        sb.delete();
        for (int a = 0; a < l1; a++) begin
            int b0;
            b0 = trm ? a + 1 : l0;
            for (int b = 0; b < b0; b++) begin
                e.i1  = 8'(a);
                e.i0  = 8'(b);
                e.lst = {(b == b0 - 1) && (a == l1 - 1), (b == b0 - 1)};
                sb.push_back(e);
            end
        end
        n = sb.size();
        limit = {8'(l1), 8'(l0)};
        tri_mode = trm;
        start = 1'b1;
        tick();
        start = 1'b0;
        limit = 16'h0101;
        tri_mode = 1'b0;
        seen_done = 1'b0;
        for (int cyc = 0; cyc < 400 && !seen_done; cyc++) begin
            ready = (mode == 0) || (cyc % 4 == 0) || (cyc % 4 == 3);
            if (done) begin
                seen_done = 1'b1;
                checks++;
                if (sb.size() != 0 || valid !== 1'b0 || busy !== 1'b0) begin
                    failures++;
                    $display("FAIL %s_done_state: left=%0d valid=%b busy=%b, required left=0 valid=0 busy=0",
                             nm, sb.size(), valid, busy);
                end
                if (mode == 0) begin
                    checks++;
                    if (cyc != n) begin
                        failures++;
                        $display("FAIL %s_latency: done in cycle %0d, required %0d", nm, cyc, n);
                    end
                end
            end else if (valid) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL %s_extra_tuple: idx=%h, required no tuple", nm, idx);
                end else begin
                    e = sb[0];
                    if ({idx, last, busy} !== {e.i1, e.i0, e.lst, 1'b1}) begin
                        failures++;
                        $display("FAIL %s_tuple: idx=%h last=%b busy=%b, required idx=%h%h last=%b busy=1",
                                 nm, idx, last, busy, e.i1, e.i0, e.lst);
                    end
                    if (ready) void'(sb.pop_front());
                end
            end else begin
                checks++;
                failures++;
                $display("FAIL %s_valid_drop: valid=0 in cycle %0d, required 1", nm, cyc);
            end
            if (!seen_done) tick();
        end
        if (!seen_done) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: done=0, required a done pulse", nm);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1;
        limit = 16'h0304;
        tick();
        tick();
        checks++;
        if ({idx, valid, busy, done, last} !== 21'd0 || {s_idx, s_valid, s_busy, s_done, s_last} !== 12'd0) begin
            failures++;
            $display("FAIL reset_outputs: idx=%h v=%b b=%b d=%b last=%b s_idx=%h, required all zero",
                     idx, valid, busy, done, last, s_idx);
        end
        rst = 1'b0;
        start = 1'b0;
        tick();
    endtask

    task automatic test_full();
        run_seq(3, 4, 1'b0, 0, "full");
        tick();
        checks++;
        if (done !== 1'b0 || valid !== 1'b0 || idx !== 16'h0) begin
            failures++;
            $display("FAIL full_after_done: done=%b valid=%b idx=%h, required 0 0 0000", done, valid, idx);
        end
        tick();
    endtask

    task automatic test_tri();
        run_seq(3, 0, 1'b1, 0, "tri");
        tick();
        tick();
    endtask

    task automatic test_stall();
        run_seq(3, 4, 1'b0, 1, "stall");
        ready = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_zero();
        limit = {8'd5, 8'd0};
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (valid !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL zero_len: valid=%b done=%b busy=%b, required 0 1 0", valid, done, busy);
        end
        tick();
        checks++;
        if (valid !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL zero_len_after: valid=%b done=%b, required 0 0", valid, done);
        end
        tick();
    endtask

    // A start in the FIN cycle is dropped; the one right after it is honoured.
    task automatic test_back_to_back();
        run_seq(2, 2, 1'b0, 0, "b2b_first");
        limit = 16'h0202;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_fin_start: valid=%b done=%b busy=%b, required 0 0 0", valid, done, busy);
        end
        run_seq(2, 3, 1'b0, 0, "b2b_second");
        tick();
        tick();
    endtask

    task automatic test_abort(input bit use_rst, input string nm);
        bit found;
        limit = 16'h0304;
        start = 1'b1;
        ready = 1'b1;
        tick();
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            if (valid && idx === 16'h0102) found = 1'b1;
            else tick();
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL %s_reach: tuple 0102 not seen, required within 50 cycles", nm);
        end
        if (use_rst) rst = 1'b1;
        else clear = 1'b1;
        tick();
        rst = 1'b0;
        clear = 1'b0;
        checks++;
        if ({idx, valid, busy, done, last} !== 21'd0) begin
            failures++;
            $display("FAIL %s_abort: idx=%h v=%b b=%b d=%b last=%b, required all zero",
                     nm, idx, valid, busy, done, last);
        end
        tick();
        checks++;
        if (done !== 1'b0 || valid !== 1'b0) begin
            failures++;
            $display("FAIL %s_no_done: done=%b valid=%b, required 0 0", nm, done, valid);
        end
        run_seq(3, 4, 1'b0, 0, {nm, "_restart"});
        tick();
        tick();
    endtask

    task automatic test_single();
        bit seen_done;
        sq.delete();
        for (int v = 0; v < 255; v++) sq.push_back(v);
        s_limit = 8'd255;
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        seen_done = 1'b0;
        for (int cyc = 0; cyc < 400 && !seen_done; cyc++) begin
            if (cyc == 100) begin
                s_start = 1'b1;
                s_limit = 8'd3;
            end else begin
                s_start = 1'b0;
            end
            if (s_done) begin
                seen_done = 1'b1;
                checks++;
                if (sq.size() != 0 || cyc != 255 || s_busy !== 1'b0) begin
                    failures++;
                    $display("FAIL single_done: left=%0d cycle=%0d busy=%b, required 0 255 0",
                             sq.size(), cyc, s_busy);
                end
            end else if (s_valid && sq.size() != 0) begin
                checks++;
                if (s_idx !== 8'(sq[0]) || s_last !== 1'((sq[0] == 254))) begin
                    failures++;
                    $display("FAIL single_tuple: idx=%0d last=%b, required idx=%0d last=%b",
                             s_idx, s_last, sq[0], (sq[0] == 254));
                end
                void'(sq.pop_front());
            end else begin
                checks++;
                failures++;
                $display("FAIL single_stream: valid=%b left=%0d in cycle %0d, required valid=1",
                         s_valid, sq.size(), cyc);
            end
            if (!seen_done) tick();
        end
        s_start = 1'b0;
        if (!seen_done) begin
            checks++;
            failures++;
            $display("FAIL single_timeout: done=0, required a done pulse");
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_full();
        test_tri();
        test_stall();
        test_zero();
        test_back_to_back();
        test_abort(1'b0, "clear");
        test_abort(1'b1, "rst");
        test_single();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
